// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its RAM.
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam logic [ADDR_W-1:0] IO_ADDR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;
endpackage

// File: rtl/ram_sp.sv
// Single-port byte RAM: synchronous write, combinational read, never cleared.
module ram_sp
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/mem_responder.sv
// Bus slave with wait states: RAM at the bottom of the map, one I/O port,
// four-phase ready handshake and an error flag for bad or unmapped accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                WAIT_CYCLES = 1,
  parameter int                RAM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);
  localparam int          IDX_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = RAM_DEPTH;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;

  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              sel_ram, sel_io;

  // Decode works on the latched address so bus changes mid-access are ignored.
  assign sel_ram = 32'(addr_q) < DEPTH_U;
  assign sel_io  = (addr_q == IO_ADDR);

  ram_sp #(
    .DEPTH (RAM_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    io_out_d = io_out_q;
    ram_we   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (read && write) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (read || write) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = write ? OP_WRITE : OP_READ;
          err_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (sel_ram) begin
            // A reset landing on the access edge must not corrupt RAM.
            if (op_q == OP_WRITE) ram_we = !rst;
            else                  rdata_d = ram_rdata;
          end else if (sel_io) begin
            if (op_q == OP_WRITE) io_out_d = wdata_q;
            else                  rdata_d  = io_in;
          end else begin
            err_d = 1'b1;
            if (op_q == OP_READ) rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (!read && !write) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= OP_READ;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      io_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      io_out_q <= io_out_d;
    end
  end

  assign ready  = (state_q == S_DONE);
  assign err    = ready & err_q;
  assign rdata  = rdata_q;
  assign io_out = io_out_q;
endmodule

// File: tb/tb_mem_responder.sv
// Three responders (0, 1 and 3 wait states) driven with directed and random
// accesses; a monitor checks every ready pulse against a queued expectation.
module tb_mem_responder;
  localparam int NU = 3;

  typedef struct {
    int         u;
    int         t;
    int         lat;
    bit         chk_rd;
    logic [7:0] rd;
    logic       err;
    logic [7:0] io;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_s   [NU];
  logic [15:0] addr_s [NU];
  logic [7:0] wdata_s [NU];
  logic       read_s  [NU];
  logic       write_s [NU];
  logic [7:0] rdata_w [NU];
  logic       ready_w [NU];
  logic       err_w   [NU];
  logic [7:0] io_in_s [NU];
  logic [7:0] io_out_w[NU];

  exp_t       sbq[$];
  logic [7:0] mmem [NU][256];
  bit         mkn  [NU][256];
  logic [7:0] mrd  [NU];
  bit         mrdk [NU];
  logic [7:0] mio  [NU];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit prev_rdy [NU];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    mem_responder #(
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .RAM_DEPTH   (256),
      .IO_ADDR     (16'hFFFF)
    ) u_dut (
      .clk    (clk),
      .rst    (rst_s[g]),
      .addr   (addr_s[g]),
      .wdata  (wdata_s[g]),
      .read   (read_s[g]),
      .write  (write_s[g]),
      .rdata  (rdata_w[g]),
      .ready  (ready_w[g]),
      .err    (err_w[g]),
      .io_in  (io_in_s[g]),
      .io_out (io_out_w[g])
    );
  end

  function automatic int wc_of(input int u);
    return (u == 0) ? 0 : ((u == 1) ? 1 : 3);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // Monitor: pops one expectation per rising ready.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < NU; u++) begin
      if (ready_w[u] === 1'b0) check("err_without_ready", {31'd0, err_w[u]}, 32'd0);
      if (ready_w[u] === 1'b1 && !prev_rdy[u]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready u%0d: got ready=1 want ready=0", u);
        end else begin
          e = sbq.pop_front();
          check("unit", u, e.u);
          check("latency", cyc - e.t, e.lat);
          if (e.chk_rd) check("rdata", {24'd0, rdata_w[u]}, {24'd0, e.rd});
          check("err", {31'd0, err_w[u]}, {31'd0, e.err});
          check("io_out", {24'd0, io_out_w[u]}, {24'd0, e.io});
        end
      end
      prev_rdy[u] = (ready_w[u] === 1'b1);
    end
  end

  // Called on a falling edge; applies the request rules to the model, queues
  // the expectation and runs the four-phase handshake.
  task automatic access(input int u, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [7:0] d, input int hold);
    exp_t e;
    int n;
    e.u   = u;
    e.t   = cyc;
    e.lat = (rd && wr) ? 1 : wc_of(u) + 2;
    e.err = 1'b0;
    if (rd && wr) begin
      e.err = 1'b1;
    end else if (a < 16'd256) begin
      if (wr) begin
        mmem[u][a[7:0]] = d;
        mkn[u][a[7:0]]  = 1'b1;
      end else begin
        mrd[u]  = mmem[u][a[7:0]];
        mrdk[u] = mkn[u][a[7:0]];
      end
    end else if (a == 16'hFFFF) begin
      if (wr) mio[u] = d;
      else begin
        mrd[u]  = io_in_s[u];
        mrdk[u] = 1'b1;
      end
    end else begin
      e.err = 1'b1;
      if (rd) begin
        mrd[u]  = 8'h00;
        mrdk[u] = 1'b1;
      end
    end
    e.rd     = mrd[u];
    e.chk_rd = mrdk[u];
    e.io     = mio[u];
    sbq.push_back(e);

    addr_s[u]  = a;
    wdata_s[u] = d;
    read_s[u]  = rd;
    write_s[u] = wr;
    @(negedge clk);
    addr_s[u]  = 16'($urandom);
    wdata_s[u] = 8'($urandom);
    n = 0;
    while (ready_w[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready_w[u] !== 1'b1) check("ready_timeout", {31'd0, ready_w[u]}, 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check("ready_held", {31'd0, ready_w[u]}, 32'd1);
    end
    read_s[u]  = 1'b0;
    write_s[u] = 1'b0;
    @(negedge clk);
    check("ready_drop", {31'd0, ready_w[u]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u, r, r2, hold;
    logic [15:0] a;
    bit rd, wr;
    for (int i = 0; i < NU; i++) begin
      rst_s[i] = 1'b1; addr_s[i] = '0; wdata_s[i] = '0;
      read_s[i] = 1'b0; write_s[i] = 1'b0; io_in_s[i] = '0;
      mrd[i] = 8'h00; mrdk[i] = 1'b1; mio[i] = 8'h00;
      for (int j = 0; j < 256; j++) mkn[i][j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      check("reset_ready",  {31'd0, ready_w[i]}, 32'd0);
      check("reset_err",    {31'd0, err_w[i]}, 32'd0);
      check("reset_rdata",  {24'd0, rdata_w[i]}, 32'd0);
      check("reset_io_out", {24'd0, io_out_w[i]}, 32'd0);
      rst_s[i] = 1'b0;
    end
    @(negedge clk);

    access(1, 0, 1, 16'h0010, 8'h5A, 0);
    access(1, 1, 0, 16'h0010, 8'h00, 0);
    access(1, 0, 1, 16'hFFFF, 8'hC3, 0);
    io_in_s[1] = 8'h81;
    access(1, 1, 0, 16'hFFFF, 8'h00, 1);
    access(1, 0, 1, 16'h0000, 8'h11, 0);
    access(1, 1, 0, 16'h0100, 8'h00, 0);
    access(1, 0, 1, 16'h0100, 8'hEE, 0);
    access(1, 1, 0, 16'h0000, 8'h00, 0);
    access(1, 0, 1, 16'h00FF, 8'h77, 0);
    access(1, 1, 0, 16'h00FF, 8'h00, 0);
    access(1, 1, 1, 16'h0000, 8'h99, 4);
    access(1, 1, 0, 16'h0000, 8'h00, 2);
    access(0, 0, 1, 16'h0000, 8'hA5, 0);
    access(0, 1, 0, 16'h0000, 8'h00, 0);

    // Reset lands while the 3-wait-state write is still counting down.
    access(2, 0, 1, 16'h0020, 8'h3C, 0);
    addr_s[2] = 16'h0020; wdata_s[2] = 8'hFF; write_s[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst_s[2] = 1'b1; write_s[2] = 1'b0;
    @(negedge clk);
    rst_s[2] = 1'b0;
    mrd[2] = 8'h00; mrdk[2] = 1'b1; mio[2] = 8'h00;
    check("abort_rdata",  {24'd0, rdata_w[2]}, 32'd0);
    check("abort_io_out", {24'd0, io_out_w[2]}, 32'd0);
    repeat (8) begin
      @(negedge clk);
      check("abort_no_ready", {31'd0, ready_w[2]}, 32'd0);
    end
    access(2, 1, 0, 16'h0020, 8'h00, 0);

    for (int i = 0; i < 200; i++) begin
      u = $urandom_range(0, NU - 1);
      r = $urandom_range(0, 9);
      if (r < 5)       a = 16'($urandom_range(0, 31));
      else if (r == 5) a = 16'h00FF;
      else if (r == 6) a = 16'h0100;
      else if (r < 9)  a = 16'hFFFF;
      else             a = 16'($urandom_range(16'h0101, 16'hFFFE));
      r2 = $urandom_range(0, 9);
      rd = (r2 < 5) || (r2 == 9);
      wr = (r2 >= 5);
      hold = $urandom_range(0, 2);
      io_in_s[u] = 8'($urandom);
      access(u, rd, wr, a, 8'($urandom), hold);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
